// File: rtl/trade_pkg.sv
// trade_pkg: shared types and timing constants for the Z-score signal stage.
//   state_t        : FSM state encoding (IDLE/SQRT/DIV/DONE), also exported for debug.
//   result_flags_t : decision flags carried with each result.
//   DEF_*          : default widths used by trade_z_seq.
//   SQRT_CYC, DIV_CYC, LATENCY : per-phase cycle counts at the default widths.
package trade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQRT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FRAC_W = 8;

  localparam int SQRT_CYC = DEF_DATA_W;
  localparam int DIV_CYC  = DEF_DATA_W + DEF_FRAC_W;
  localparam int LATENCY  = 2 * DEF_DATA_W + DEF_FRAC_W + 2;

  typedef struct packed {
    logic buy;
    logic sell;
    logic clamped;
  } result_flags_t;

  // Accept-edge to out_valid-rise distance for arbitrary widths.
  function automatic int latency_of(input int data_w, input int frac_w);
    return 2 * data_w + frac_w + 2;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// isqrt_seq: bit-serial integer square root, digit-by-digit method.
//   clk, rst : clock, synchronous active-high reset.
//   start    : load din and begin; one result bit is produced per cycle.
//   din      : IN_W-bit radicand.
//   done     : goes high on the edge producing the last root bit and stays
//              high until the next start.
//   root     : floor(sqrt(din)), IN_W/2 bits, valid while done is high.
module isqrt_seq #(
  parameter int IN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   din,
  output logic              done,
  output logic [IN_W/2-1:0] root
);

  localparam int OUT_W = IN_W / 2;
  localparam int CNT_W = $clog2(OUT_W + 1);

  logic [IN_W-1:0]  x_q;
  logic [OUT_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [OUT_W+1:0] rem_sh;
  logic [OUT_W+1:0] trial;
  logic             ge;
  logic [OUT_W-1:0] rem_nx;

  // Before every iteration the partial remainder fits in OUT_W bits; only the
  // final remainder may be wider and it is never used, so the low OUT_W bits
  // of the modular difference are all that must be kept.
  always_comb begin
    rem_sh = {rem_q, x_q[IN_W-1 -: 2]};
    trial  = {root, 2'b01};
    ge     = (rem_sh >= trial);
    rem_nx = ge ? (rem_sh[OUT_W-1:0] - trial[OUT_W-1:0]) : rem_sh[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
      root   <= '0;
    end else if (start) begin
      x_q    <= din;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done   <= 1'b0;
      root   <= '0;
    end else if (busy_q) begin
      x_q   <= x_q << 2;
      rem_q <= rem_nx;
      root  <= {root[OUT_W-2:0], ge};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(OUT_W - 1)) begin
        busy_q <= 1'b0;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/trade_z_seq.sv
// trade_z_seq: per-tick Z-score buy/sell signal generator with sequential
// square root and restoring division.
//   clk, rst    : clock, synchronous active-high reset.
//   in_valid/in_ready : input tuple handshake (n_mean, n_sqr_mean, cur_data).
//   out_valid/out_ready : result handshake (buy_signal, sell_signal, z_score,
//                 var_clamped).
//   dbg_state   : current FSM state.
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; a raised valid and its payload stay unchanged until that edge.
// Timing: accept edge, then DATA_W+1 cycles in SQRT (root load + DATA_W bits),
// DATA_W+FRAC_W+1 cycles in DIV (quotient bits + result register), so
// out_valid rises 2*DATA_W+FRAC_W+2 edges after the accept edge.
module trade_z_seq
  import trade_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int Z_THRESH = 100,
  parameter int COOLDOWN = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        n_mean,
  input  logic [2*DATA_W-1:0]      n_sqr_mean,
  input  logic [DATA_W-1:0]        cur_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     buy_signal,
  output logic                     sell_signal,
  output logic [DATA_W+FRAC_W-1:0] z_score,
  output logic                     var_clamped,
  output state_t                   dbg_state
);

  localparam int ZW    = DATA_W + FRAC_W;
  localparam int DIV_N = DATA_W + FRAC_W;
  localparam int CNT_W = $clog2(DIV_N + 1);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  state_t          state_q;
  result_flags_t   res_q;
  logic [CD_W-1:0] cd_q;

  logic [DATA_W-1:0] delta_q;
  logic              below_q;
  logic              above_q;
  logic              clamp_q;

  logic [DATA_W-1:0] div_rem_q;
  logic [ZW-1:0]     div_quo_q;
  logic [DATA_W-1:0] div_sor_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [2*DATA_W-1:0] mean_sq;
  logic                under;
  logic [2*DATA_W-1:0] var_in;
  logic                accept;
  logic                sqrt_done;
  logic [DATA_W-1:0]   sqrt_root;

  logic [DATA_W:0]   rem_sh;
  logic              q_bit;
  logic [DATA_W-1:0] rem_nx;
  logic [ZW-1:0]     z_fin;
  logic              hit;

  assign accept  = in_valid && in_ready;
  assign mean_sq = {{DATA_W{1'b0}}, n_mean} * {{DATA_W{1'b0}}, n_mean};
  assign under   = (n_sqr_mean < mean_sq);
  assign var_in  = under ? '0 : (n_sqr_mean - mean_sq);

  isqrt_seq #(.IN_W(2 * DATA_W)) u_isqrt (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .din   (var_in),
    .done  (sqrt_done),
    .root  (sqrt_root)
  );

  // Restoring division step; with sd==0 the step still runs (every bit
  // compares as 1) and the quotient is overridden below.
  always_comb begin
    rem_sh = {div_rem_q, div_quo_q[ZW-1]};
    q_bit  = (rem_sh >= {1'b0, div_sor_q});
    rem_nx = q_bit ? (rem_sh[DATA_W-1:0] - div_sor_q) : rem_sh[DATA_W-1:0];
    z_fin  = (div_sor_q == '0) ? '0 : div_quo_q;
    hit    = (z_fin > ZW'(Z_THRESH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      z_score     <= '0;
      res_q       <= '0;
      cd_q        <= '0;
      delta_q     <= '0;
      below_q     <= 1'b0;
      above_q     <= 1'b0;
      clamp_q     <= 1'b0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      div_sor_q   <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            delta_q  <= (cur_data >= n_mean) ? (cur_data - n_mean) : (n_mean - cur_data);
            below_q  <= (cur_data < n_mean);
            above_q  <= (cur_data > n_mean);
            clamp_q  <= under;
            in_ready <= 1'b0;
            state_q  <= SQRT;
          end
        end
        SQRT: begin
          if (sqrt_done) begin
            div_sor_q <= sqrt_root;
            div_quo_q <= {delta_q, {FRAC_W{1'b0}}};
            div_rem_q <= '0;
            cnt_q     <= '0;
            state_q   <= DIV;
          end
        end
        DIV: begin
          if (cnt_q == CNT_W'(DIV_N)) begin
            z_score       <= z_fin;
            res_q.buy     <= hit && below_q && (cd_q == '0);
            res_q.sell    <= hit && above_q && (cd_q == '0);
            res_q.clamped <= clamp_q;
            out_valid     <= 1'b1;
            state_q       <= DONE;
          end else begin
            div_rem_q <= rem_nx;
            div_quo_q <= {div_quo_q[ZW-2:0], q_bit};
            cnt_q     <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
            if (cd_q != '0) begin
              cd_q <= cd_q - 1'b1;
            end else if (res_q.buy || res_q.sell) begin
              cd_q <= CD_W'(COOLDOWN);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buy_signal  = res_q.buy;
  assign sell_signal = res_q.sell;
  assign var_clamped = res_q.clamped;
  assign dbg_state   = state_q;

endmodule
